// File: rtl/conv_output_collector.sv
// Collects per-kernel result streams into the output RAM via per-kernel FIFOs and a round-robin writer.
// Build option COLLECTOR_STATUS_WORD_EN: appends a RUN cycle-count word at STATUS_ADDR before done_o.
module conv_output_collector #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned N_KERNELS   = 64,
    parameter int unsigned OUTPUT_SIZE = 4,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned STATUS_ADDR = N_KERNELS * OUTPUT_SIZE
) (
    input  logic                                 clock_i,
    input  logic                                 reset_n_i,
    input  logic                                 enable_i,
    input  logic [N_KERNELS-1:0][DATA_WIDTH-1:0] data_i,
    input  logic [N_KERNELS-1:0]                 data_valid_i,
    output logic [ADDR_WIDTH-1:0]                ram_address_o,
    output logic [DATA_WIDTH-1:0]                ram_data_o,
    output logic                                 ram_wren_o,
    output logic                                 done_o,
    output logic                                 overflow_o
);

    localparam int unsigned KW    = (N_KERNELS > 1) ? $clog2(N_KERNELS) : 1;
    localparam int unsigned PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned AW    = $clog2(OUTPUT_SIZE + 1);
    localparam int unsigned TOTAL = N_KERNELS * OUTPUT_SIZE;
    localparam int unsigned WW    = $clog2(TOTAL + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd3;
`ifdef COLLECTOR_STATUS_WORD_EN
    localparam logic [1:0] S_STATUS = 2'd2;
`endif

    if (64'(STATUS_ADDR) >= (64'(1) << ADDR_WIDTH)) begin : g_bad_status_addr
        $error("STATUS_ADDR does not fit in ADDR_WIDTH");
    end

    logic [1:0]            state_q, state_d;
    logic [KW-1:0]         ptr_q, ptr_d;
    logic [WW-1:0]         written_q, written_d;
    logic                  wren_q, wren_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
`ifdef COLLECTOR_STATUS_WORD_EN
    logic [DATA_WIDTH-1:0] cycle_q, cycle_d;
`endif

    logic [DATA_WIDTH-1:0] mem_q [N_KERNELS][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [N_KERNELS][FIFO_DEPTH];
    logic [PW-1:0]         rd_q  [N_KERNELS];
    logic [PW-1:0]         rd_d  [N_KERNELS];
    logic [PW-1:0]         wr_q  [N_KERNELS];
    logic [PW-1:0]         wr_d  [N_KERNELS];
    logic [CW-1:0]         cnt_q [N_KERNELS];
    logic [CW-1:0]         cnt_d [N_KERNELS];
    logic [AW-1:0]         acc_q [N_KERNELS];
    logic [AW-1:0]         acc_d [N_KERNELS];
    logic [AW-1:0]         idx_q [N_KERNELS];
    logic [AW-1:0]         idx_d [N_KERNELS];

    logic                  arb_found;
    logic [KW-1:0]         arb_sel;
    logic [N_KERNELS-1:0]  pop_v;
    logic [N_KERNELS-1:0]  push_v;

    // Round-robin pick: first non-empty FIFO at or after ptr_q, wrapping.
    always_comb begin
        int unsigned j;
        arb_found = 1'b0;
        arb_sel   = '0;
        j         = 0;
        for (int unsigned i = 0; i < N_KERNELS; i++) begin
            j = 32'(ptr_q) + i;
            if (j >= N_KERNELS) j = j - N_KERNELS;
            if (!arb_found && cnt_q[KW'(j)] != '0) begin
                arb_found = 1'b1;
                arb_sel   = KW'(j);
            end
        end
    end

    // Next state: pop/write first, then capture so a full FIFO popped this edge can still accept.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        written_d = written_q;
        wren_d    = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        done_d    = done_q;
        ovf_d     = ovf_q;
`ifdef COLLECTOR_STATUS_WORD_EN
        cycle_d   = cycle_q;
`endif
        mem_d     = mem_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        pop_v     = '0;
        push_v    = '0;

        case (state_q)
            S_IDLE: begin
                if (enable_i) state_d = S_RUN;
            end
            S_RUN: begin
`ifdef COLLECTOR_STATUS_WORD_EN
                cycle_d = cycle_q + DATA_WIDTH'(1);
`endif
                if (arb_found) begin
                    pop_v[arb_sel]  = 1'b1;
                    wren_d          = 1'b1;
                    data_d          = mem_q[arb_sel][rd_q[arb_sel]];
                    addr_d          = ADDR_WIDTH'(BASE_ADDR)
                                    + ADDR_WIDTH'(arb_sel) * ADDR_WIDTH'(OUTPUT_SIZE)
                                    + ADDR_WIDTH'(idx_q[arb_sel]);
                    idx_d[arb_sel]  = idx_q[arb_sel] + AW'(1);
                    rd_d[arb_sel]   = rd_q[arb_sel] + PW'(1);
                    ptr_d           = (32'(arb_sel) == N_KERNELS - 1) ? '0 : arb_sel + KW'(1);
                    written_d       = written_q + WW'(1);
                    if (written_q == WW'(TOTAL - 1)) begin
`ifdef COLLECTOR_STATUS_WORD_EN
                        state_d = S_STATUS;
`else
                        state_d = S_DONE;
                        done_d  = 1'b1;
`endif
                    end
                end
                for (int unsigned k = 0; k < N_KERNELS; k++) begin
                    if (data_valid_i[KW'(k)] && acc_q[KW'(k)] != AW'(OUTPUT_SIZE)) begin
                        acc_d[KW'(k)] = acc_q[KW'(k)] + AW'(1);
                        if (cnt_q[KW'(k)] == CW'(FIFO_DEPTH) && !pop_v[KW'(k)]) begin
                            ovf_d = 1'b1;
                        end else begin
                            push_v[KW'(k)]                = 1'b1;
                            mem_d[KW'(k)][wr_q[KW'(k)]]   = data_i[KW'(k)];
                            wr_d[KW'(k)]                  = wr_q[KW'(k)] + PW'(1);
                        end
                    end
                    cnt_d[KW'(k)] = cnt_q[KW'(k)] + CW'(push_v[KW'(k)]) - CW'(pop_v[KW'(k)]);
                end
            end
`ifdef COLLECTOR_STATUS_WORD_EN
            S_STATUS: begin
                wren_d  = 1'b1;
                addr_d  = ADDR_WIDTH'(STATUS_ADDR);
                data_d  = cycle_q;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            written_q <= '0;
            wren_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef COLLECTOR_STATUS_WORD_EN
            cycle_q   <= '0;
`endif
            rd_q      <= '{default: '0};
            wr_q      <= '{default: '0};
            cnt_q     <= '{default: '0};
            acc_q     <= '{default: '0};
            idx_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            written_q <= written_d;
            wren_q    <= wren_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
`ifdef COLLECTOR_STATUS_WORD_EN
            cycle_q   <= cycle_d;
`endif
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
        end
    end

    // FIFO storage needs no reset: occupancy counters define validity.
    always_ff @(posedge clock_i) begin
        mem_q <= mem_d;
    end

    assign ram_address_o = addr_q;
    assign ram_data_o    = data_q;
    assign ram_wren_o    = wren_q;
    assign done_o        = done_q;
    assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_conv_output_collector.sv
// Randomized bench for conv_output_collector against a queue-based reference model (N_KERNELS=4, FIFO_DEPTH=2).
module tb_conv_output_collector;

    localparam int NK    = 4;
    localparam int OS    = 4;
    localparam int FD    = 2;
    localparam int TOTAL = NK * OS;
    localparam int SADDR = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 enable = 1'b0;
    logic [NK-1:0][31:0]  data;
    logic [NK-1:0]        valid;
    logic [15:0]          ram_address_o;
    logic [31:0]          ram_data_o;
    logic                 ram_wren_o;
    logic                 done_o;
    logic                 overflow_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int c0 = 0;
    int wr_count = 0;
    int status_cyc = 0;
    logic [31:0] status_val = '0;
    logic [15:0] obs_addr [$];
    bit checking = 1'b0;

    // Reference model state
    logic [31:0] mq [NK][$];
    int m_acc [NK];
    int m_idx [NK];
    int m_ptr, m_written, m_phase, m_got;
    logic [31:0] m_cycles;
    logic        e_wren, e_done, e_ovf;
    logic [15:0] e_addr;
    logic [31:0] e_data;

    conv_output_collector #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (32),
        .N_KERNELS  (NK),
        .OUTPUT_SIZE(OS),
        .FIFO_DEPTH (FD),
        .BASE_ADDR  (0),
        .STATUS_ADDR(SADDR)
    ) dut (
        .clock_i      (clk),
        .reset_n_i    (rst_n),
        .enable_i     (enable),
        .data_i       (data),
        .data_valid_i (valid),
        .ram_address_o(ram_address_o),
        .ram_data_o   (ram_data_o),
        .ram_wren_o   (ram_wren_o),
        .done_o       (done_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: each RUN edge writes the head of the first non-empty queue from ptr, then captures valids.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NK; k++) begin
                mq[k].delete();
                m_acc[k] = 0;
                m_idx[k] = 0;
            end
            m_ptr = 0; m_written = 0; m_phase = 0; m_cycles = '0;
            e_wren = 1'b0; e_addr = '0; e_data = '0; e_done = 1'b0; e_ovf = 1'b0;
        end else begin
            e_wren = 1'b0;
            case (m_phase)
                0: if (enable) m_phase = 1;
                1: begin
                    m_cycles = m_cycles + 1;
                    m_got = -1;
                    for (int i = 0; i < NK; i++)
                        if (m_got < 0 && mq[(m_ptr + i) % NK].size() > 0) m_got = (m_ptr + i) % NK;
                    if (m_got >= 0) begin
                        e_wren = 1'b1;
                        e_data = mq[m_got].pop_front();
                        e_addr = 16'(m_got * OS + m_idx[m_got]);
                        m_idx[m_got]++;
                        m_ptr = (m_got + 1) % NK;
                        m_written++;
                    end
                    for (int k = 0; k < NK; k++) begin
                        if (valid[k] && m_acc[k] < OS) begin
                            m_acc[k]++;
                            if (mq[k].size() >= FD) e_ovf = 1'b1;
                            else mq[k].push_back(data[k]);
                        end
                    end
                    if (m_written == TOTAL) begin
`ifdef COLLECTOR_STATUS_WORD_EN
                        m_phase = 2;
`else
                        m_phase = 3;
                        e_done  = 1'b1;
`endif
                    end
                end
                2: begin
                    e_wren = 1'b1; e_addr = 16'(SADDR); e_data = m_cycles;
                    e_done = 1'b1; m_phase = 3;
                end
                default: ;
            endcase
        end
    end

    // Per-cycle comparison of all outputs, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            check("wren", 32'(ram_wren_o), 32'(e_wren));
            check("addr", 32'(ram_address_o), 32'(e_addr));
            check("data", ram_data_o, e_data);
            check("done", 32'(done_o), 32'(e_done));
            check("ovf", 32'(overflow_o), 32'(e_ovf));
            if (rst_n && ram_wren_o) begin
                wr_count++;
                obs_addr.push_back(ram_address_o);
                if (ram_address_o == 16'(SADDR)) begin
                    status_val = ram_data_o;
                    status_cyc = cyc;
                end
            end
        end
    end

    task automatic drive(input logic [NK-1:0] v, input logic [NK-1:0][31:0] d);
        @(negedge clk);
        valid = v;
        data  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive('0, '0);
    endtask

    function automatic logic [NK-1:0][31:0] rand_data();
        logic [NK-1:0][31:0] d;
        for (int k = 0; k < NK; k++) d[k] = $urandom;
        return d;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0; enable = 1'b0; valid = '0;
        #1;
        check("rst_wren", 32'(ram_wren_o), 32'd0);
        check("rst_addr", 32'(ram_address_o), 32'd0);
        check("rst_data", ram_data_o, 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_ovf", 32'(overflow_o), 32'd0);
        repeat (3) @(negedge clk);
        wr_count = 0;
        obs_addr.delete();
        c0 = cyc;
        rst_n = 1'b1;
        enable = 1'b1;
    endtask

    task automatic rand_run(input int pct);
        int sent [NK];
        logic [NK-1:0] v;
        logic [NK-1:0][31:0] d;
        bit all_sent;
        for (int k = 0; k < NK; k++) sent[k] = 0;
        all_sent = 1'b0;
        for (int c = 0; c < 300 && !all_sent; c++) begin
            v = '0;
            d = rand_data();
            all_sent = 1'b1;
            for (int k = 0; k < NK; k++) begin
                if (sent[k] < OS && int'($urandom % 100) < pct) begin
                    v[k] = 1'b1;
                    sent[k]++;
                end
                if (sent[k] < OS) all_sent = 1'b0;
            end
            drive(v, d);
        end
        idle(30);
        check("rand_done", 32'(done_o), 32'(all_sent && !overflow_o));
        // Valids after completion must be ignored
        drive('1, rand_data());
        idle(4);
    endtask

    initial begin
        logic [NK-1:0][31:0] d;
        int n;
        valid = '0;
        data  = '0;

        // Single kernel stream on k=2
        do_reset();
        checking = 1'b1;
        for (int i = 0; i < OS; i++) begin
            d = '0;
            d[2] = 32'h10 + 32'(i);
            drive(4'b0100, d);
            idle(2);
        end
        idle(5);
        check("s1_writes", 32'(wr_count), 32'd4);
        for (int i = 0; i < OS; i++) check("s1_addr", 32'(obs_addr[i]), 32'(8 + i));
        check("s1_done", 32'(done_o), 32'd0);

        // Four simultaneous bursts, rotation order
        do_reset();
        for (int b = 0; b < OS; b++) begin
            for (int k = 0; k < NK; k++) d[k] = 32'hA0 + 32'(k);
            drive('1, d);
            idle(2);
        end
        idle(12);
        for (int i = 0; i < TOTAL; i++) check("s2_rot_addr", 32'(obs_addr[i]), 32'((i % NK) * OS + i / NK));
        check("s2_ovf", 32'(overflow_o), 32'd0);
        check("s2_done", 32'(done_o), 32'd1);
`ifdef COLLECTOR_STATUS_WORD_EN
        check("s2_writes", 32'(wr_count), 32'(TOTAL + 1));
        check("s2_status_cnt", status_val, 32'(status_cyc - 2 - c0));
`else
        check("s2_writes", 32'(wr_count), 32'(TOTAL));
`endif

        // Saturating input: overflow, dropped slots, extra valid ignored
        do_reset();
        repeat (4) drive('1, rand_data());
        idle(12);
        check("s3_ovf", 32'(overflow_o), 32'd1);
        check("s3_done", 32'(done_o), 32'd0);
        check("s3_dropped", 32'(wr_count < TOTAL), 32'd1);
        n = wr_count;
        drive(4'b0001, rand_data());
        idle(6);
        check("s3_extra_ignored", 32'(wr_count), 32'(n));

        // Mid-run reset after 6 writes, then restart
        do_reset();
        for (int i = 0; i < 60 && wr_count < 6; i++) drive(4'($urandom), rand_data());
        check("s4_reached6", 32'(wr_count >= 6), 32'd1);
        do_reset();
        rand_run(30);

        // Further random densities
        do_reset();
        rand_run(70);
        do_reset();
        rand_run(15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
